// File: rtl/fp_enco_if.sv
// rtl/fp_enco_if.sv - operand/result handshake bundle for the fp_enco float packer
interface fp_enco_if #(
    parameter int MW = 48
);
    logic          In_valid;
    logic          In_ready;
    logic          Signo_R;
    logic [9:0]    Exponente_R;
    logic [MW-1:0] Mantissa_R;
    logic          Out_valid;
    logic          Out_ready;
    logic [31:0]   Float_num_R;
    logic          Overflow;
    logic          Underflow;

    modport slave (
        input  In_valid, Signo_R, Exponente_R, Mantissa_R, Out_ready,
        output In_ready, Out_valid, Float_num_R, Overflow, Underflow
    );

    modport master (
        output In_valid, Signo_R, Exponente_R, Mantissa_R, Out_ready,
        input  In_ready, Out_valid, Float_num_R, Overflow, Underflow
    );
endinterface

// File: rtl/fp_enco.sv
// rtl/fp_enco.sv - iterative normalize, round-to-nearest-even and pack to IEEE-754 single
module fp_enco #(
    parameter int MW = 48
) (
    input  logic      clk,
    input  logic      rst_n,
    fp_enco_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_NORM, S_ROUND, S_DONE} state_t;

    state_t               r_state, w_state_nxt;
    logic                 r_sign, w_sign_nxt;
    logic signed [10:0]   r_e, w_e_nxt;
    logic [MW-1:0]        r_m, w_m_nxt;
    logic                 r_zero, w_zero_nxt;
    logic [31:0]          r_float, w_float_nxt;
    logic                 r_ovf, w_ovf_nxt;
    logic                 r_unf, w_unf_nxt;
    logic                 r_out_valid, w_out_valid_nxt;

    logic [22:0]          w_frac;
    logic                 w_g;
    logic                 w_s;
    logic                 w_inc;
    logic [23:0]          w_frac_sum;
    logic signed [10:0]   w_e_rnd;

    // Sticky covers everything below the guard bit; nothing remains when MW is 26.
    if (MW > 26) begin : g_sticky
        assign w_s = |r_m[MW-27:0];
    end else begin : g_no_sticky
        assign w_s = 1'b0;
    end

    assign w_frac     = r_m[MW-3:MW-25];
    assign w_g        = r_m[MW-26];
    assign w_inc      = w_g & (w_s | w_frac[0]);
    assign w_frac_sum = {1'b0, w_frac} + {23'd0, w_inc};
    assign w_e_rnd    = r_e + {10'd0, w_frac_sum[23]};

    always_comb begin
        w_state_nxt     = r_state;
        w_sign_nxt      = r_sign;
        w_e_nxt         = r_e;
        w_m_nxt         = r_m;
        w_zero_nxt      = r_zero;
        w_float_nxt     = r_float;
        w_ovf_nxt       = r_ovf;
        w_unf_nxt       = r_unf;
        w_out_valid_nxt = r_out_valid;

        case (r_state)
            S_IDLE: begin
                if (bus.In_valid) begin
                    w_sign_nxt  = bus.Signo_R;
                    w_e_nxt     = {bus.Exponente_R[9], bus.Exponente_R};
                    w_m_nxt     = bus.Mantissa_R;
                    w_zero_nxt  = 1'b0;
                    w_state_nxt = S_NORM;
                end
            end
            S_NORM: begin
                if (r_m == '0) begin
                    w_zero_nxt  = 1'b1;
                    w_state_nxt = S_ROUND;
                end else if (r_m[MW-1]) begin
                    w_m_nxt = {1'b0, r_m[MW-1:2], r_m[1] | r_m[0]};
                    w_e_nxt = r_e + 11'sd1;
                end else if (r_m[MW-2]) begin
                    w_state_nxt = S_ROUND;
                end else if (r_e <= 11'sd0) begin
                    w_state_nxt = S_ROUND;
                end else begin
                    w_m_nxt = r_m << 1;
                    w_e_nxt = r_e - 11'sd1;
                end
            end
            S_ROUND: begin
                w_ovf_nxt = 1'b0;
                w_unf_nxt = 1'b0;
                if (r_zero) begin
                    w_float_nxt = {r_sign, 31'd0};
                end else if (w_e_rnd >= 11'sd255) begin
                    w_float_nxt = {r_sign, 8'hFF, 23'd0};
                    w_ovf_nxt   = 1'b1;
                end else if (w_e_rnd <= 11'sd0) begin
                    w_float_nxt = {r_sign, 31'd0};
                    w_unf_nxt   = 1'b1;
                end else begin
                    w_float_nxt = {r_sign, w_e_rnd[7:0], w_frac_sum[22:0]};
                end
                w_e_nxt         = w_e_rnd;
                w_out_valid_nxt = 1'b1;
                w_state_nxt     = S_DONE;
            end
            S_DONE: begin
                if (bus.Out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sign      <= 1'b0;
            r_e         <= '0;
            r_m         <= '0;
            r_zero      <= 1'b0;
            r_float     <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sign      <= w_sign_nxt;
            r_e         <= w_e_nxt;
            r_m         <= w_m_nxt;
            r_zero      <= w_zero_nxt;
            r_float     <= w_float_nxt;
            r_ovf       <= w_ovf_nxt;
            r_unf       <= w_unf_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    assign bus.In_ready    = (r_state == S_IDLE);
    assign bus.Out_valid   = r_out_valid;
    assign bus.Float_num_R = r_float;
    assign bus.Overflow    = r_ovf;
    assign bus.Underflow   = r_unf;
endmodule

// File: tb/tb_fp_enco.sv
// tb/tb_fp_enco.sv - directed vector table plus handshake and reset sequences for fp_enco
module tb_fp_enco;
    logic clk;
    logic rst_n;

    fp_enco_if #(.MW(48)) bus ();

    fp_enco #(.MW(48)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sign;
        logic [9:0]  ex;
        logic [47:0] m;
        logic [31:0] f;
        logic        ovf;
        logic        unf;
        int          lat;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic sign, input logic [9:0] ex, input logic [47:0] m);
        int n;
        n = 0;
        while (!bus.In_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_issue", {31'd0, bus.In_ready}, 32'd1);
        bus.Signo_R     = sign;
        bus.Exponente_R = ex;
        bus.Mantissa_R  = m;
        bus.In_valid    = 1'b1;
        @(posedge clk);
        #1;
        bus.In_valid    = 1'b0;
        bus.Signo_R     = ~sign;
        bus.Exponente_R = 10'h155;
        bus.Mantissa_R  = 48'hFFFF_FFFF_FFFF;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (bus.Out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic release_out(input string name);
        bus.Out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.Out_ready = 1'b0;
        chk({name, "_valid_drop"}, {31'd0, bus.Out_valid}, 32'd0);
        chk({name, "_in_ready"}, {31'd0, bus.In_ready}, 32'd1);
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int lat;
        start_op(v.sign, v.ex, v.m);
        wait_out(lat);
        chk({name, "_latency"}, lat, v.lat);
        chk({name, "_float"}, bus.Float_num_R, v.f);
        chk({name, "_flags"}, {30'd0, bus.Overflow, bus.Underflow}, {30'd0, v.ovf, v.unf});
        release_out(name);
    endtask

    vec_t vecs[13];

    initial begin
        int lat;
        logic [31:0] held;

        vecs[0]  = '{1'b0, 10'd127, 48'h4000_0000_0000, 32'h3F80_0000, 1'b0, 1'b0, 2};
        vecs[1]  = '{1'b0, 10'd127, 48'h8000_0000_0000, 32'h4000_0000, 1'b0, 1'b0, 3};
        vecs[2]  = '{1'b0, 10'd129, 48'h1000_0000_0000, 32'h3F80_0000, 1'b0, 1'b0, 4};
        vecs[3]  = '{1'b0, 10'd127, 48'h4000_0040_0000, 32'h3F80_0000, 1'b0, 1'b0, 2};
        vecs[4]  = '{1'b0, 10'd127, 48'h4000_00C0_0000, 32'h3F80_0002, 1'b0, 1'b0, 2};
        vecs[5]  = '{1'b0, 10'd127, 48'h4000_0040_0001, 32'h3F80_0001, 1'b0, 1'b0, 2};
        vecs[6]  = '{1'b0, 10'd127, 48'h7FFF_FFC0_0000, 32'h4000_0000, 1'b0, 1'b0, 2};
        vecs[7]  = '{1'b1, 10'd300, 48'h4000_0000_0000, 32'hFF80_0000, 1'b1, 1'b0, 2};
        vecs[8]  = '{1'b0, 10'h3FB, 48'h4000_0000_0000, 32'h0000_0000, 1'b0, 1'b1, 2};
        vecs[9]  = '{1'b1, 10'd127, 48'h0000_0000_0000, 32'h8000_0000, 1'b0, 1'b0, 2};
        vecs[10] = '{1'b1, 10'd128, 48'h6000_0000_0000, 32'hC040_0000, 1'b0, 1'b0, 2};
        vecs[11] = '{1'b1, 10'd1,   48'h1000_0000_0000, 32'h8000_0000, 1'b0, 1'b1, 3};
        vecs[12] = '{1'b0, 10'd254, 48'h8000_0000_0000, 32'h7F80_0000, 1'b1, 1'b0, 3};

        rst_n           = 1'b0;
        bus.In_valid    = 1'b0;
        bus.Out_ready   = 1'b0;
        bus.Signo_R     = 1'b0;
        bus.Exponente_R = '0;
        bus.Mantissa_R  = '0;
        #12;
        chk("reset_in_ready", {31'd0, bus.In_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, bus.Out_valid}, 32'd0);
        chk("reset_float", bus.Float_num_R, 32'd0);
        chk("reset_flags", {30'd0, bus.Overflow, bus.Underflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // In_valid held high with other data during NORM must not disturb the operation.
        start_op(1'b0, 10'd129, 48'h1000_0000_0000);
        bus.In_valid   = 1'b1;
        bus.Mantissa_R = 48'h8000_0000_0000;
        wait_out(lat);
        bus.In_valid   = 1'b0;
        chk("busy_ignore_latency", lat, 4);
        chk("busy_ignore_float", bus.Float_num_R, 32'h3F80_0000);
        held = bus.Float_num_R;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", {31'd0, bus.Out_valid}, 32'd1);
            chk("hold_float", bus.Float_num_R, held);
            chk("hold_in_ready", {31'd0, bus.In_ready}, 32'd0);
        end
        release_out("hold");

        // Asynchronous reset in the middle of a left-shift sequence.
        start_op(1'b0, 10'd129, 48'h1000_0000_0000);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", {31'd0, bus.Out_valid}, 32'd0);
        chk("midreset_float", bus.Float_num_R, 32'd0);
        chk("midreset_in_ready", {31'd0, bus.In_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_vec(vecs[0], "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
